multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 op  input  7  opcode, Instr[6:0] from the instruction register.
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7b5  input  1  Instr[30].
REQ-007 Zero  input  1  ALU zero flag, same cycle.
REQ-008 MemReady  input  1  unified memory access completes this cycle.
REQ-009 PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  write enables.
REQ-010 AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
REQ-011 ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-012 ALUSrcB  output  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
REQ-013 ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-016 Illegal  output  1  sticky flag for an unsupported opcode.

Function
REQ-017 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, JAL, ALUWB, BRANCH, ERROR.
REQ-018 Outputs SHALL be combinational from the state plus the listed inputs; any enable not listed for a state SHALL be 0.
REQ-019 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=MemReady; advance to DECODE only when MemReady=1, else hold.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target); next state by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1101111->JAL, 1100011->BRANCH, any other->ERROR.
REQ-021 MEMADR: ALUSrcA=10, ALUSrcB=01, add; next MEMREAD if op=lw, else MEMWRITE.
REQ-022 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady, then MEMWB.
REQ-023 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-024 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held continuously until MemReady=1; next FETCH.
REQ-025 EXECR: ALUSrcA=10, ALUSrcB=00, funct-decoded ALUControl; next ALUWB.
REQ-026 EXECI: ALUSrcA=10, ALUSrcB=01, funct-decoded ALUControl; next ALUWB.
REQ-027 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-028 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-029 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=Zero XOR funct3[0] (beq/bne); next FETCH.
REQ-030 ERROR: all enables 0, Illegal=1; no exit except reset.
REQ-031 ImmSrc SHALL be decoded from op in every state: lw/I-ALU 00, sw 01, branch 10, jal 11, otherwise 00.
REQ-032 Funct decode: funct3 000 gives sub only when op[5]&funct7b5, else add; 010 slt; 100 xor; 110 or; 111 and; 001/011/101 give add.
REQ-033 Instruction latency (MemReady always 1): lw 5, sw 4, R/I-ALU 4, jal 4, branch 3 cycles.

Reset
REQ-034 While reset=1, state SHALL be FETCH and every enable and Illegal SHALL be 0; select outputs follow FETCH values.
REQ-035 Reset asserted mid-instruction (including in a MemReady wait) SHALL abort it immediately; no RegWrite or MemWrite in the cycle after release unless FETCH conditions apply.
REQ-036 The first FETCH after release SHALL assert IRWrite/PCWrite only when MemReady=1.

Structure
REQ-037 Package mc_pkg SHALL hold the state enum, opcode constants, and ALUControl/ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings.
REQ-038 Funct decoding SHALL be sub-module mc_alu_decode (inputs: ALU-op class, funct3, funct7b5, op[5]).

Verification
REQ-039 Reset mid-MEMWRITE with MemReady=0 -> MemWrite=0 immediately; state FETCH; Illegal=0.
REQ-040 lw (op 0000011) with MemReady low 2 cycles in FETCH and 3 in MEMREAD -> RegWrite high exactly 1 cycle in MEMWB, 10 cycles after fetch start.
REQ-041 beq, Zero=1 -> PCWrite=1 in BRANCH; bne (funct3=001), Zero=1 -> PCWrite=0; ALUControl=001 both.
REQ-042 R-type sub (funct3=000, funct7b5=1) -> ALUControl=001; addi with funct7b5=1 -> ALUControl=000.
REQ-043 sw with MemReady held 0 for 4 cycles -> MemWrite=1 for 5 consecutive cycles, then FETCH.
REQ-044 op=0110111 -> ERROR after DECODE, Illegal=1 held 20 cycles with all enables 0 until reset.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StJal,
    StAluWb,
    StBranch,
    StError
  } state_e;

  // ALU operation class handed to the funct decoder
  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } alu_op_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU control decode: maps the operation class and funct fields to an ALU
// operation code.
module mc_alu_decode import mc_pkg::*; (
  input  alu_op_e     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = AluAdd;
    case (alu_op)
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct3)
          // Only R-type (op[5]=1) can select sub; addi ignores funct7.
          3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b100:  alu_control = AluXor;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: alu_control = AluAdd;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: FSM sequencing fetch, decode, memory,
// ALU and branch steps, with outputs decoded from the current state.
module multicycle_ctrl import mc_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    pc_write, ir_write, reg_write, mem_write, illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRs2;
    ResultSrc = ResAluOut;
    alu_op    = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        ir_write  = MemReady;
        pc_write  = MemReady;
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBranch;
          default:         state_d = StError;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = ResData;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (MemReady) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = SrcARs1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StJal: begin
        ALUSrcA  = SrcAOldPc;
        ALUSrcB  = SrcBFour;
        pc_write = 1'b1;
        state_d  = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA  = SrcARs1;
        alu_op   = AluOpSub;
        pc_write = Zero ^ funct3[0];
        state_d  = StFetch;
      end
      StError: illegal = 1'b1;
      default: state_d = StError;
    endcase
  end

  mc_alu_decode u_alu_decode (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  assign ImmSrc = imm_sel(op);

  // Reset forces FETCH asynchronously; masking keeps its MemReady-driven
  // enables quiet while reset is still held.
  assign PCWrite  = pc_write  & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign Illegal  = illegal   & ~reset;

endmodule
